// File: rtl/gcd_controller.sv
// gcd_controller: sequencer for a 16-bit subtractive GCD datapath.
// Loads operand A then operand B from the shared data_in bus, then issues
// one subtract-and-load per cycle, driven by the A/B comparator, until the
// registers match. A subtraction limit turns a non-converging run (such as
// a zero operand) into an error completion instead of a hang.
module gcd_controller #(
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 255   // must be > 0 and < 2**ITER_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              lt,
    input  logic              gt,
    input  logic              eq,
    output logic              ldA,
    output logic              ldB,
    output logic              sel1,
    output logic              sel2,
    output logic              sel_in,
    output logic              op_sel,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ITER_W-1:0] iter_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_COMPUTE,
        S_DONE
    } state_e;

    // What a COMPUTE cycle does, resolved once from abort, flags and the limit.
    typedef enum logic [2:0] {
        ACT_HOLD,        // no flag set: wait, no load
        ACT_SUB_A,       // A > B: A <= A - B
        ACT_SUB_B,       // A < B: B <= B - A
        ACT_FINISH_OK,   // A == B: result ready
        ACT_FINISH_ERR,  // limit reached without convergence
        ACT_ABORT        // cancel back to IDLE, no load
    } action_e;

    localparam logic [ITER_W-1:0] MAX_CNT = ITER_W'(MAX_ITER);

    state_e             state_q, state_d;
    action_e            act;
    logic [ITER_W-1:0]  iter_count_q, iter_count_d;
    logic               err_q, err_d;

    // Resolve the COMPUTE-cycle action: abort > eq > limit > gt > lt > hold.
    // The limit test sits above gt/lt so a saturated counter can never be
    // incremented again, which also keeps iter_count from wrapping.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        act = ACT_HOLD;
        if (abort) begin
            act = ACT_ABORT;
        end else if (eq) begin
            act = ACT_FINISH_OK;
        end else if (iter_count_q == MAX_CNT) begin
            act = ACT_FINISH_ERR;
        end else if (gt) begin
            act = ACT_SUB_A;
        end else if (lt) begin
            act = ACT_SUB_B;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                state_d = abort ? S_IDLE : S_LOAD_B;
            end
            S_LOAD_B: begin
                state_d = abort ? S_IDLE : S_COMPUTE;
            end
            S_COMPUTE: begin
                unique case (act)
                    ACT_ABORT:      state_d = S_IDLE;
                    ACT_FINISH_OK:  state_d = S_DONE;
                    ACT_FINISH_ERR: state_d = S_DONE;
                    default:        state_d = S_COMPUTE;
                endcase
            end
            S_DONE: begin
                // A start seen here is deliberately dropped; it is only
                // sampled once back in IDLE.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Iteration counter and error flag: cleared on accepted start, updated
    // by COMPUTE actions, otherwise held so software can read them later.
    always_comb begin
        iter_count_d = iter_count_q;
        err_d        = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    iter_count_d = '0;
                    err_d        = 1'b0;
                end
            end
            S_COMPUTE: begin
                unique case (act)
                    ACT_SUB_A,
                    ACT_SUB_B:      iter_count_d = iter_count_q + ITER_W'(1);
                    ACT_FINISH_OK:  err_d = 1'b0;
                    ACT_FINISH_ERR: err_d = 1'b1;
                    default:        ;
                endcase
            end
            default: ;
        endcase
    end

    // Counter and error flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter_count_q <= '0;
            err_q        <= 1'b0;
        end else begin
            iter_count_q <= iter_count_d;
            err_q        <= err_d;
        end
    end

    // Output decode: Moore on state, Mealy on abort/flags during loads/COMPUTE.
    always_comb begin
        ldA    = 1'b0;
        ldB    = 1'b0;
        sel1   = 1'b0;
        sel2   = 1'b0;
        sel_in = 1'b0;
        op_sel = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        err    = 1'b0;
        unique case (state_q)
            S_LOAD_A: begin
                busy   = 1'b1;
                sel_in = 1'b1;
                op_sel = 1'b0;
                ldA    = !abort;
            end
            S_LOAD_B: begin
                busy   = 1'b1;
                sel_in = 1'b1;
                op_sel = 1'b1;
                ldB    = !abort;
            end
            S_COMPUTE: begin
                busy   = 1'b1;
                sel_in = 1'b0;
                unique case (act)
                    ACT_SUB_A: begin
                        sel1 = 1'b0;
                        sel2 = 1'b1;
                        ldA  = 1'b1;
                    end
                    ACT_SUB_B: begin
                        sel1 = 1'b1;
                        sel2 = 1'b0;
                        ldB  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_DONE: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

    assign iter_count = iter_count_q;

endmodule

// File: tb/tb_gcd_controller.sv
// tb_gcd_controller: directed bench for gcd_controller. Surrounds the
// controller with a behavioural GCD datapath (A/B registers, subtract muxes,
// bus mux, comparator) plus an operand source, and checks control outputs,
// latency and results against hand-computed values.
module tb_gcd_controller;

    localparam int ITER_W   = 8;
    localparam int MAX_ITER = 16;

    logic              clk = 1'b0;
    logic              rst_n, start, abort;
    logic              lt, gt, eq;
    logic              ldA, ldB, sel1, sel2, sel_in, op_sel, busy, done, err;
    logic [ITER_W-1:0] iter_count;

    // Datapath and operand source model.
    logic [15:0] a_q = '0, b_q = '0;
    logic [15:0] op_a, op_b, data_in, x_bus, y_bus, bus;
    logic        ovr_en, ovr_lt, ovr_gt, ovr_eq;

    int vectors     = 0;
    int miscompares = 0;

    // Packed view: {ldA, ldB, sel1, sel2, sel_in, op_sel, busy, done, err}
    logic [8:0] outs;
    assign outs = {ldA, ldB, sel1, sel2, sel_in, op_sel, busy, done, err};

    gcd_controller #(
        .ITER_W   (ITER_W),
        .MAX_ITER (MAX_ITER)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .lt         (lt),
        .gt         (gt),
        .eq         (eq),
        .ldA        (ldA),
        .ldB        (ldB),
        .sel1       (sel1),
        .sel2       (sel2),
        .sel_in     (sel_in),
        .op_sel     (op_sel),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .iter_count (iter_count)
    );

    always #5 clk = ~clk;

    assign data_in = op_sel ? op_b : op_a;
    assign x_bus   = sel1 ? b_q : a_q;
    assign y_bus   = sel2 ? b_q : a_q;
    assign bus     = sel_in ? data_in : (x_bus - y_bus);
    assign lt      = ovr_en ? ovr_lt : (a_q < b_q);
    assign gt      = ovr_en ? ovr_gt : (a_q > b_q);
    assign eq      = ovr_en ? ovr_eq : (a_q == b_q);

    always @(posedge clk) begin
        if (ldA) a_q <= bus;
        if (ldB) b_q <= bus;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while IDLE; returns at the negedge of cycle 1.
    task automatic kick(input logic [15:0] a, input logic [15:0] b, input bit hold_start);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold_start) start = 1'b0;
    endtask

    // Steps negedge by negedge from cycle 'from' until done (bounded).
    task automatic wait_done(input string tag, input int from, output int cyc,
                             output int ldb_pulses, output bit both_high);
        cyc        = from;
        ldb_pulses = 0;
        both_high  = 1'b0;
        while (done !== 1'b1 && cyc < 400) begin
            if (ldB === 1'b1) ldb_pulses++;
            if (ldA === 1'b1 && ldB === 1'b1) both_high = 1'b1;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done_seen"}, done, 1);
    endtask

    initial begin
        int cyc, pulses;
        bit both, both_any, seen_done;

        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        ovr_en = 1'b0;
        ovr_lt = 1'b0;
        ovr_gt = 1'b0;
        ovr_eq = 1'b0;
        op_a   = '0;
        op_b   = '0;
        both_any = 1'b0;

        // Reset state
        #12;
        check("reset_outs", outs, 9'b0);
        check("reset_iter", iter_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outs", outs, 9'b0);

        // 48,18: gt,gt,lt,gt then eq; done in cycle 8
        kick(16'd48, 16'd18, 1'b0);
        check("g48_c1_outs", outs, 9'b1_0_0_0_1_0_1_0_0);
        @(negedge clk);
        check("g48_c2_outs", outs, 9'b0_1_0_0_1_1_1_0_0);
        @(negedge clk);
        check("g48_c3_a", a_q, 48);
        check("g48_c3_b", b_q, 18);
        check("g48_c3_outs", outs, 9'b1_0_0_1_0_0_1_0_0);
        wait_done("g48", 3, cyc, pulses, both);
        both_any |= both;
        check("g48_cycle", cyc, 8);
        check("g48_outs_done", outs, 9'b0_0_0_0_0_0_0_1_0);
        check("g48_a", a_q, 6);
        check("g48_b", b_q, 6);
        check("g48_iter", iter_count, 4);
        @(negedge clk);
        check("g48_idle_outs", outs, 9'b0);
        check("g48_iter_held", iter_count, 4);

        // Asynchronous reset in the middle of COMPUTE
        kick(16'd48, 16'd18, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_outs", outs, 9'b0);
        check("rst_mid_iter", iter_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        kick(16'd48, 16'd18, 1'b0);
        wait_done("rst_rerun", 1, cyc, pulses, both);
        both_any |= both;
        check("rst_rerun_cycle", cyc, 8);
        check("rst_rerun_a", a_q, 6);
        check("rst_rerun_iter", iter_count, 4);
        @(negedge clk);

        // Equal operands: no subtraction, done in cycle 4
        kick(16'd12, 16'd12, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("eq12_c3_outs", outs, 9'b0_0_0_0_0_0_1_0_0);
        check("eq12_iter_cleared", iter_count, 0);
        @(negedge clk);
        check("eq12_c4_outs", outs, 9'b0_0_0_0_0_0_0_1_0);
        check("eq12_a", a_q, 12);
        @(negedge clk);

        // Zero operand: 16 ldB pulses, then done with err in cycle 20
        kick(16'd0, 16'd7, 1'b0);
        @(negedge clk);
        @(negedge clk);
        wait_done("zero", 3, cyc, pulses, both);
        both_any |= both;
        check("zero_cycle", cyc, 20);
        check("zero_ldb_pulses", pulses, 16);
        check("zero_outs_done", outs, 9'b0_0_0_0_0_0_0_1_1);
        check("zero_iter", iter_count, 16);
        check("zero_b", b_q, 7);
        @(negedge clk);
        check("zero_idle_err", err, 0);
        check("zero_iter_held", iter_count, 16);

        // Abort in the second COMPUTE cycle (100,75 -> A=25 after first)
        kick(16'd100, 16'd75, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        #1;
        check("abort_c4_ld_busy", {ldA, ldB, busy, done}, 4'b0010);
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle_outs", outs, 9'b0);
        check("abort_iter", iter_count, 1);
        check("abort_a", a_q, 25);
        check("abort_b", b_q, 75);
        seen_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1'b1;
        end
        check("abort_no_done", seen_done, 0);

        // Flag priority with illegal / empty flag combinations
        kick(16'd9, 16'd4, 1'b0);
        @(negedge clk);
        @(negedge clk);
        ovr_en = 1'b1; ovr_gt = 1'b1; ovr_lt = 1'b1; ovr_eq = 1'b0;
        #1;
        check("prio_gt_over_lt", {ldA, ldB, sel1, sel2}, 4'b1001);
        @(negedge clk);
        ovr_gt = 1'b0; ovr_lt = 1'b0; ovr_eq = 1'b0;
        #1;
        check("prio_noflag_hold", {ldA, ldB, busy, done}, 4'b0010);
        check("prio_a_after_sub", a_q, 5);
        @(negedge clk);
        ovr_gt = 1'b1; ovr_eq = 1'b1;
        #1;
        check("prio_eq_over_gt", {ldA, ldB, busy, done}, 4'b0010);
        @(negedge clk);
        ovr_en = 1'b0; ovr_gt = 1'b0; ovr_eq = 1'b0;
        check("prio_done_outs", outs, 9'b0_0_0_0_0_0_0_1_0);
        check("prio_iter", iter_count, 1);
        check("prio_a_held", a_q, 5);
        @(negedge clk);

        // start held high: ignored while busy and in DONE, restart after IDLE
        kick(16'd48, 16'd18, 1'b1);
        wait_done("held", 1, cyc, pulses, both);
        both_any |= both;
        check("held_cycle", cyc, 8);
        @(negedge clk);
        check("held_c9_idle", {ldA, busy, done}, 3'b000);
        @(negedge clk);
        check("held_c10_load_a", {ldA, op_sel, busy}, 3'b101);
        start = 1'b0;
        wait_done("held2", 10, cyc, pulses, both);
        both_any |= both;
        check("held2_cycle", cyc, 17);
        check("held2_a", a_q, 6);
        check("held2_iter", iter_count, 4);
        check("ld_never_both", both_any, 0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
